// File: rtl/perceptron_pkg.sv
// perceptron_pkg: opcodes, reply codes, FSM state codes
// and the saturating add used by the learning rule.
package perceptron_pkg;

    localparam logic [7:0] OP_LOAD_W   = 8'hA0;
    localparam logic [7:0] OP_LOAD_B   = 8'hA1;
    localparam logic [7:0] OP_CLASSIFY = 8'hA2;
    localparam logic [7:0] OP_TRAIN    = 8'hA3;
    localparam logic [7:0] OP_READ_W   = 8'hA4;

    localparam logic [7:0] ACK = 8'h55;
    localparam logic [7:0] NAK = 8'hEE;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RX_W   = 4'd1;
    localparam logic [3:0] S_RX_B   = 4'd2;
    localparam logic [3:0] S_RX_X   = 4'd3;
    localparam logic [3:0] S_RX_T   = 4'd4;
    localparam logic [3:0] S_MAC    = 4'd5;
    localparam logic [3:0] S_DECIDE = 4'd6;
    localparam logic [3:0] S_UPDATE = 4'd7;
    localparam logic [3:0] S_TX     = 4'd8;

    // a +/- b clamped to the signed range of a wd-bit value
    function automatic logic signed [7:0] sat_add(
        input logic signed [7:0] a,
        input logic signed [7:0] b,
        input logic              sub,
        input int                wd
    );
        logic signed [9:0] ea, eb, s, hi, lo;
        ea = {{2{a[7]}}, a};
        eb = {{2{b[7]}}, b};
        s  = sub ? ea - eb : ea + eb;
        hi = (10'sd1 <<< (wd - 1)) - 10'sd1;
        lo = -hi - 10'sd1;
        if (s > hi)      return hi[7:0];
        else if (s < lo) return lo[7:0];
        else             return s[7:0];
    endfunction

endpackage

// File: rtl/perceptron_core_if.sv
// perceptron_core_if: byte-stream command side (UART rx/tx)
// plus the status outputs of the perceptron engine.
interface perceptron_core_if;
    logic [7:0] data_in;
    logic       in;
    logic       tx_busy;
    logic [7:0] data_out;
    logic       out;
    logic       busy;
    logic       overrun;
    logic       class_out;

    modport master (
        output data_in, in, tx_busy,
        input  data_out, out, busy, overrun, class_out
    );

    modport slave (
        input  data_in, in, tx_busy,
        output data_out, out, busy, overrun, class_out
    );
endinterface

// File: rtl/perceptron_mac.sv
// perceptron_mac: one signed multiplier feeding an accumulator
// that is cleared, preloaded with the bias, or accumulates.
module perceptron_mac #(
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load,
    input  logic signed [W-1:0]     bias,
    input  logic                    en,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (load)
            acc <= ACC_W'(bias);
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/perceptron_core.sv
// perceptron_core: command FSM, weight/bias registers, learning
// rule and reply sequencing around a sequential MAC.
import perceptron_pkg::*;

module perceptron_core #(
    parameter int N_IN  = 4,
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input logic               clk,
    input logic               rst,
    perceptron_core_if.slave  bus
);

    localparam int IW = $clog2(N_IN + 1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

    logic [3:0]          state;
    logic [IW-1:0]       idx;
    logic signed [W-1:0] w_q [N_IN];
    logic signed [W-1:0] x_q [N_IN];
    logic signed [W-1:0] b_q;
    logic                train_q, t_q, y_q;
    logic                readw_q, wait_q;
    logic [7:0]          reply_q;
    logic                overrun_q, class_q;

    logic signed [W-1:0]     din, w_sel, x_sel;
    logic signed [ACC_W-1:0] acc;
    logic signed [7:0]       upd_w, upd_b;
    logic [7:0]              tx_byte;
    logic                    last, y, busy;
    logic                    tx_fire, mac_load, mac_clr, mac_en;

    assign din  = bus.data_in[W-1:0];
    assign last = (idx == IW'(N_IN - 1));
    assign y    = (acc >= ACC_ZERO);

    always_comb begin
        w_sel = '0;
        x_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx == IW'(i)) begin
                w_sel = w_q[i];
                x_sel = x_q[i];
            end
        end
    end

    assign upd_w = sat_add(8'(w_sel), 8'(x_sel), ~t_q, W);
    assign upd_b = sat_add(8'(b_q), 8'sd1, ~t_q, W);

    // READ_W streams w[0..N-1] then the bias, all sign-extended
    assign tx_byte = !readw_q ? reply_q :
                     (idx == IW'(N_IN)) ? 8'(b_q) : 8'(w_sel);

    assign busy = (state == S_MAC) || (state == S_DECIDE) ||
                  (state == S_UPDATE) || (state == S_TX);

    assign tx_fire  = (state == S_TX) && !wait_q && !bus.tx_busy;
    assign mac_clr  = (state == S_IDLE);
    assign mac_en   = (state == S_MAC);
    assign mac_load = bus.in &&
                      ((state == S_RX_X && last && !train_q) ||
                       state == S_RX_T);

    assign bus.out       = tx_fire;
    assign bus.data_out  = tx_fire ? tx_byte : 8'h00;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun_q;
    assign bus.class_out = class_q;

    perceptron_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (mac_clr),
        .load (mac_load),
        .bias (b_q),
        .en   (mac_en),
        .a    (w_sel),
        .b    (x_sel),
        .acc  (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            b_q       <= '0;
            train_q   <= 1'b0;
            t_q       <= 1'b0;
            y_q       <= 1'b0;
            readw_q   <= 1'b0;
            wait_q    <= 1'b0;
            reply_q   <= '0;
            overrun_q <= 1'b0;
            class_q   <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            // the UART raises busy one cycle after a request
            wait_q <= tx_fire;
            if (bus.in && busy)
                overrun_q <= 1'b1;
            case (state)
                S_IDLE: if (bus.in) begin
                    idx     <= '0;
                    readw_q <= 1'b0;
                    case (bus.data_in)
                        OP_LOAD_W: state <= S_RX_W;
                        OP_LOAD_B: state <= S_RX_B;
                        OP_CLASSIFY: begin
                            train_q <= 1'b0;
                            state   <= S_RX_X;
                        end
                        OP_TRAIN: begin
                            train_q <= 1'b1;
                            state   <= S_RX_X;
                        end
                        OP_READ_W: begin
                            readw_q <= 1'b1;
                            state   <= S_TX;
                        end
                        default: begin
                            reply_q <= NAK;
                            state   <= S_TX;
                        end
                    endcase
                end
                S_RX_W: if (bus.in) begin
                    for (int i = 0; i < N_IN; i++)
                        if (idx == IW'(i)) w_q[i] <= din;
                    if (last) begin
                        idx     <= '0;
                        reply_q <= ACK;
                        state   <= S_TX;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_RX_B: if (bus.in) begin
                    b_q     <= din;
                    reply_q <= ACK;
                    state   <= S_TX;
                end
                S_RX_X: if (bus.in) begin
                    for (int i = 0; i < N_IN; i++)
                        if (idx == IW'(i)) x_q[i] <= din;
                    if (last) begin
                        idx   <= '0;
                        state <= train_q ? S_RX_T : S_MAC;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_RX_T: if (bus.in) begin
                    t_q   <= bus.data_in[0];
                    state <= S_MAC;
                end
                S_MAC: begin
                    if (last) begin
                        idx   <= '0;
                        state <= S_DECIDE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DECIDE: begin
                    class_q <= y;
                    y_q     <= y;
                    if (train_q && (y != t_q)) begin
                        state <= S_UPDATE;
                    end else begin
                        reply_q <= {6'b0, 1'b0, y};
                        state   <= S_TX;
                    end
                end
                S_UPDATE: begin
                    if (idx == IW'(N_IN)) begin
                        b_q     <= W'(upd_b);
                        reply_q <= {6'b0, 1'b1, y_q};
                        idx     <= '0;
                        state   <= S_TX;
                    end else begin
                        for (int i = 0; i < N_IN; i++)
                            if (idx == IW'(i)) w_q[i] <= W'(upd_w);
                        idx <= idx + IW'(1);
                    end
                end
                S_TX: if (tx_fire) begin
                    if (!readw_q || idx == IW'(N_IN)) begin
                        idx   <= '0;
                        state <= S_IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_core.sv
// tb_perceptron_core: directed vector table, corner sequences and
// a randomized command stream checked against an integer model.
module tb_perceptron_core;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    perceptron_core_if bus ();

    perceptron_core #(.N_IN(N), .W(8), .ACC_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // simple UART model: busy for a random time after each request
    logic force_busy = 1'b0;
    int   uart_max   = 0;
    int   ucnt       = 0;
    always @(posedge clk) begin
        if (rst)          ucnt <= 0;
        else if (bus.out) ucnt <= $urandom_range(0, uart_max);
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end
    assign bus.tx_busy = force_busy || (ucnt != 0);

    int viol = 0;
    int prev_out = 0;
    always @(negedge clk) begin
        #2;
        if (bus.out && bus.tx_busy) viol++;
        if (bus.out && prev_out != 0) viol++;
        prev_out = bus.out;
    end

    logic [7:0] cmdq[$];
    logic [7:0] rxq[$];
    int last_strobe, first_out;

    typedef struct {
        bit          rst_first;
        int          nb;
        int          nr;
        logic [47:0] bs;
        logic [39:0] es;
    } vec_t;
    vec_t tab[$];

    int mw[N];
    int mb;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int rx(input int i);
        return (rxq.size() > i) ? int'(rxq[i]) : -1;
    endfunction

    function automatic int sx(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic int clamp(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    function automatic void add(input bit r, input int nb, input int nr,
                                input logic [47:0] bs,
                                input logic [39:0] es);
        vec_t v;
        v.rst_first = r;
        v.nb = nb;
        v.nr = nr;
        v.bs = bs;
        v.es = es;
        tab.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mb = 0;
        for (int i = 0; i < N; i++) mw[i] = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.data_in = b;
        bus.in      = 1'b1;
        last_strobe = cyc;
        @(negedge clk);
        bus.in      = 1'b0;
    endtask

    task automatic collect(input int n);
        int waited = 0;
        rxq.delete();
        first_out = -1;
        while (rxq.size() < n && waited < 400) begin
            #1;
            if (bus.out) begin
                if (first_out < 0) first_out = cyc;
                rxq.push_back(bus.data_out);
            end
            @(negedge clk);
            waited++;
        end
        if (rxq.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d bytes expected %0d",
                     rxq.size(), n);
        end
    endtask

    task automatic run(input int nr);
        foreach (cmdq[i]) send_byte(cmdq[i]);
        cmdq.delete();
        collect(nr);
    endtask

    task automatic quiet(input int cycles, input string nm);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            #1;
            if (bus.out) cnt++;
        end
        chk(nm, cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int op, acc, y, t, upd;
        int cnt, rel;
        logic [7:0] xb[N];
        logic [7:0] bb;

        bus.data_in = '0;
        bus.in      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out",      int'(bus.out), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_busy",     int'(bus.busy), 0);
        chk("rst_overrun",  int'(bus.overrun), 0);
        chk("rst_class",    int'(bus.class_out), 0);

        add(1, 1, 5, 48'hA4_0000000000, 40'h00_00000000);
        add(0, 5, 1, 48'hA0_01020304_00, 40'h55_00000000);
        add(0, 2, 1, 48'hA1_FF_00000000, 40'h55_00000000);
        add(0, 5, 1, 48'hA2_01010101_00, 40'h01_00000000);
        add(0, 5, 1, 48'hA2_FFFFFFFF_00, 40'h00_00000000);
        add(1, 6, 1, 48'hA3_01020304_00, 40'h03_00000000);
        add(0, 1, 5, 48'hA4_0000000000, 40'hFFFEFDFCFF);
        add(0, 6, 1, 48'hA3_01020304_00, 40'h00_00000000);
        add(0, 1, 5, 48'hA4_0000000000, 40'hFFFEFDFCFF);
        add(0, 5, 1, 48'hA0_7F000000_00, 40'h55_00000000);
        add(0, 2, 1, 48'hA1_80_00000000, 40'h55_00000000);
        add(0, 6, 1, 48'hA3_01000000_01, 40'h02_00000000);
        add(0, 1, 5, 48'hA4_0000000000, 40'h7F00000081);
        add(0, 1, 1, 48'h10_0000000000, 40'hEE_00000000);

        foreach (tab[k]) begin
            if (tab[k].rst_first) do_reset();
            for (int i = 0; i < tab[k].nb; i++)
                cmdq.push_back(tab[k].bs[47-8*i -: 8]);
            run(tab[k].nr);
            for (int i = 0; i < tab[k].nr; i++)
                chk($sformatf("vec%0d_b%0d", k, i), rx(i),
                    int'(tab[k].es[39-8*i -: 8]));
            if (tab[k].bs[47:40] == 8'hA2)
                chk($sformatf("vec%0d_latency", k),
                    first_out - last_strobe, N + 2);
            if (tab[k].bs[47:40] == 8'hA2 || tab[k].bs[47:40] == 8'hA3)
                chk($sformatf("vec%0d_class", k),
                    int'(bus.class_out), int'(tab[k].es[32]));
            #1;
            chk($sformatf("vec%0d_idle", k), int'(bus.busy), 0);
        end

        // stray byte during MAC is dropped and sets sticky overrun
        do_reset();
        #1;
        chk("ovr_clear", int'(bus.overrun), 0);
        cmdq = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04};
        run(1);
        chk("ovr_loadw", rx(0), 'h55);
        send_byte(8'hA2);
        for (int i = 0; i < N; i++) send_byte(8'h01);
        send_byte(8'hA4);
        collect(1);
        chk("ovr_reply", rx(0), 'h01);
        chk("ovr_set", int'(bus.overrun), 1);
        quiet(20, "ovr_no_extra");
        cmdq = '{8'hA1, 8'h00};
        run(1);
        chk("ovr_after", rx(0), 'h55);
        chk("ovr_sticky", int'(bus.overrun), 1);
        do_reset();
        #1;
        chk("ovr_rst", int'(bus.overrun), 0);

        // tx_busy held high; also acc == 0 must classify as 1
        force_busy = 1'b1;
        send_byte(8'hA2);
        for (int i = 0; i < N; i++) send_byte(8'h05);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (bus.out) cnt++;
        end
        chk("busy_held", cnt, 0);
        force_busy = 1'b0;
        rel = cyc;
        collect(1);
        chk("busy_reply", rx(0), 'h01);
        chk("busy_release", first_out - rel, 0);

        // reset in the middle of LOAD_W, with a strobe in the reset cycle
        cmdq = '{8'hA0, 8'h05, 8'h06, 8'h07, 8'h08};
        run(1);
        cmdq = '{8'hA1, 8'h09};
        run(1);
        send_byte(8'hA0);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst = 1'b1;
        bus.in = 1'b1;
        bus.data_in = 8'hA4;
        @(negedge clk);
        rst = 1'b0;
        bus.in = 1'b0;
        mb = 0;
        for (int i = 0; i < N; i++) mw[i] = 0;
        quiet(20, "rst_noreply");
        cmdq = '{8'hA4};
        run(5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rst_readw_b%0d", i), rx(i), 0);

        // randomized command stream against the integer model
        uart_max = 3;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    cmdq.push_back(8'hA0);
                    for (int i = 0; i < N; i++) begin
                        xb[i] = 8'($urandom);
                        cmdq.push_back(xb[i]);
                        mw[i] = sx(xb[i]);
                    end
                    run(1);
                    chk("rnd_loadw", rx(0), 'h55);
                end
                1: begin
                    bb = 8'($urandom);
                    cmdq = '{8'hA1, bb};
                    mb = sx(bb);
                    run(1);
                    chk("rnd_loadb", rx(0), 'h55);
                end
                2, 3: begin
                    cmdq.push_back(op == 2 ? 8'hA2 : 8'hA3);
                    acc = mb;
                    for (int i = 0; i < N; i++) begin
                        xb[i] = 8'($urandom);
                        cmdq.push_back(xb[i]);
                        acc += mw[i] * sx(xb[i]);
                    end
                    y = (acc >= 0) ? 1 : 0;
                    upd = 0;
                    if (op == 3) begin
                        bb = 8'($urandom);
                        cmdq.push_back(bb);
                        t = int'(bb[0]);
                        if (y != t) begin
                            upd = 1;
                            for (int i = 0; i < N; i++)
                                mw[i] = clamp(t ? mw[i] + sx(xb[i])
                                                : mw[i] - sx(xb[i]));
                            mb = clamp(t ? mb + 1 : mb - 1);
                        end
                    end
                    run(1);
                    chk(op == 2 ? "rnd_classify" : "rnd_train",
                        rx(0), upd * 2 + y);
                    chk("rnd_class_out", int'(bus.class_out), y);
                end
                default: begin
                    cmdq = '{8'hA4};
                    run(5);
                    for (int i = 0; i < N; i++)
                        chk("rnd_readw", rx(i), mw[i] & 255);
                    chk("rnd_readb", rx(N), mb & 255);
                end
            endcase
        end
        cmdq = '{8'hA4};
        run(5);
        for (int i = 0; i < N; i++)
            chk("final_readw", rx(i), mw[i] & 255);
        chk("final_readb", rx(N), mb & 255);
        chk("tx_protocol", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
